// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the arbitrated ALU: funct bit positions, the funct
// type, the response-stage state type and the 32-bit op function.
// Optional feature macro used by importers: ALU_ARB_ONEHOT_CHECK_EN.
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam int FUNCT_W = 5;
    localparam int FN_ADD  = 0;
    localparam int FN_SUB  = 1;
    localparam int FN_SLL  = 2;
    localparam int FN_SRL  = 3;
    localparam int FN_SRA  = 4;

    typedef logic [FUNCT_W-1:0] funct_t;

    // Response stage occupancy; exposed as a typed register in alu_arbiter.
    typedef enum logic {
        RSP_EMPTY = 1'b0,
        RSP_FULL  = 1'b1
    } rsp_state_e;

    // Result of every selected op ORed together, so a non-one-hot funct
    // yields the OR of the individual results and funct=0 yields 0.
    // Shift amounts are the full unsigned 32-bit b; anything >= 32 saturates.
    function automatic logic [31:0] alu_compute(input logic [31:0] a,
                                                input logic [31:0] b,
                                                input funct_t      f);
        logic [31:0] r;
        logic        big;
        big = |b[31:5];
        r   = '0;
        if (f[FN_ADD]) r = r | (a + b);
        if (f[FN_SUB]) r = r | (a - b);
        if (f[FN_SLL]) r = r | (big ? 32'd0 : (a << b[4:0]));
        if (f[FN_SRL]) r = r | (big ? 32'd0 : (a >> b[4:0]));
        if (f[FN_SRA]) r = r | (big ? {32{a[31]}} : 32'($signed(a) >>> b[4:0]));
        return r;
    endfunction

    function automatic logic is_onehot(input funct_t f);
        return (f != '0) && ((f & (f - 1'b1)) == '0);
    endfunction

endpackage

// File: rtl/alu_rr_picker.sv
// ---------------------------------------------------------------------------
// alu_rr_picker
// Combinational round-robin picker: scans i_valid starting at i_ptr, upward
// modulo N, and reports the first set index.
//   i_valid     N   request vector
//   i_ptr       PW  highest-priority index this cycle (must be < N)
//   o_grant     PW  winning index (0 when nothing is valid)
//   o_any_valid 1   at least one request is valid
// ---------------------------------------------------------------------------
module alu_rr_picker #(
    parameter int N  = 2,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  i_valid,
    input  logic [PW-1:0] i_ptr,
    output logic [PW-1:0] o_grant,
    output logic          o_any_valid
);

    logic [PW:0]   w_sum;
    logic [PW-1:0] w_idx;

    // Scan from the farthest offset down to offset 0 so the closest valid
    // index to i_ptr is the last one written and therefore wins.
    always_comb begin
        o_grant     = '0;
        o_any_valid = 1'b0;
        w_sum       = '0;
        w_idx       = '0;
        for (int k = N - 1; k >= 0; k--) begin
            w_sum = {1'b0, i_ptr} + (PW + 1)'(k);
            if (w_sum >= (PW + 1)'(N)) begin
                w_sum = w_sum - (PW + 1)'(N);
            end
            w_idx = w_sum[PW-1:0];
            if (i_valid[w_idx]) begin
                o_grant     = w_idx;
                o_any_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
// Shares one add/sub/sll/srl/sra datapath between N_REQ requesters with
// round-robin fairness, registering the result and winner ID into a
// one-entry response stage.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. A requester keeps valid and its operands stable until it sees
// ready; ready here never depends on operand values. The response stage
// holds rsp_* stable while rsp_valid=1 and rsp_ready=0.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   req_valid / req_ready      N_REQ per-requester handshake
//   req_val1 / req_val2        N_REQ x 32 operands, packed [i*32 +: 32]
//   req_funct                  N_REQ x 5 one-hot op select
//   rsp_valid / rsp_ready      response handshake
//   rsp_id, rsp_result         winner index and registered result
//   rsp_err                    non-one-hot funct flag (ALU_ARB_ONEHOT_CHECK_EN)
// Optional feature macro: ALU_ARB_ONEHOT_CHECK_EN.
// ---------------------------------------------------------------------------
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req_valid,
    output logic [N_REQ-1:0]         req_ready,
    input  logic [N_REQ*32-1:0]      req_val1,
    input  logic [N_REQ*32-1:0]      req_val2,
    input  logic [N_REQ*FUNCT_W-1:0] req_funct,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
`ifdef ALU_ARB_ONEHOT_CHECK_EN
    output logic                     rsp_err,
`endif
    output logic [31:0]              rsp_result
);

    rsp_state_e  r_state;
    logic [ID_W-1:0] r_ptr;
    logic [ID_W-1:0] r_id;
    logic [31:0]     r_result;
    logic            r_err;

    rsp_state_e      w_state_nxt;
    logic [ID_W-1:0] w_ptr_nxt;
    logic [ID_W-1:0] w_id_nxt;
    logic [31:0]     w_result_nxt;
    logic            w_err_nxt;

    logic [ID_W-1:0] w_grant;
    logic            w_any_valid;
    logic            w_can_accept;
    logic            w_accept;
    logic [31:0]     w_op_result;

    logic [31:0]     w_v1    [N_REQ];
    logic [31:0]     w_v2    [N_REQ];
    funct_t          w_funct [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign w_v1[g]    = req_val1[g*32 +: 32];
        assign w_v2[g]    = req_val2[g*32 +: 32];
        assign w_funct[g] = req_funct[g*FUNCT_W +: FUNCT_W];
    end

    alu_rr_picker #(
        .N  (N_REQ),
        .PW (ID_W)
    ) u_picker (
        .i_valid     (req_valid),
        .i_ptr       (r_ptr),
        .o_grant     (w_grant),
        .o_any_valid (w_any_valid)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= RSP_EMPTY;
            r_ptr    <= '0;
            r_id     <= '0;
            r_result <= '0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_ptr    <= w_ptr_nxt;
            r_id     <= w_id_nxt;
            r_result <= w_result_nxt;
            r_err    <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_ptr_nxt    = r_ptr;
        w_id_nxt     = r_id;
        w_result_nxt = r_result;
        w_err_nxt    = r_err;
        req_ready    = '0;

        // A full stage can be refilled in the same cycle it drains.
        // Ready is forced low while reset is held.
        w_can_accept = ~reset & ((r_state == RSP_EMPTY) | rsp_ready);
        w_accept     = w_any_valid & w_can_accept;
        w_op_result  = alu_compute(w_v1[w_grant], w_v2[w_grant], w_funct[w_grant]);

        if (w_accept) begin
            req_ready[w_grant] = 1'b1;
            w_state_nxt        = RSP_FULL;
            w_id_nxt           = w_grant;
            w_ptr_nxt          = (w_grant == ID_W'(N_REQ - 1)) ? '0 : w_grant + 1'b1;
`ifdef ALU_ARB_ONEHOT_CHECK_EN
            if (is_onehot(w_funct[w_grant])) begin
                w_result_nxt = w_op_result;
                w_err_nxt    = 1'b0;
            end else begin
                w_result_nxt = '0;
                w_err_nxt    = 1'b1;
            end
`else
            w_result_nxt = w_op_result;
            w_err_nxt    = 1'b0;
`endif
        end else if ((r_state == RSP_FULL) && rsp_ready) begin
            // Drain only; id/result keep their last value.
            w_state_nxt = RSP_EMPTY;
        end
    end

    assign rsp_valid  = (r_state == RSP_FULL);
    assign rsp_id     = r_id;
    assign rsp_result = r_result;
`ifdef ALU_ARB_ONEHOT_CHECK_EN
    assign rsp_err    = r_err;
`else
    // Error flag has no port in this build; keep the register observed.
    logic w_err_unused;
    assign w_err_unused = r_err;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

    localparam int N   = 4;
    localparam int IDW = 2;
    localparam int W   = 1 + IDW + 32;

    logic            clk;
    logic            reset;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*32-1:0] req_val1;
    logic [N*32-1:0] req_val2;
    logic [N*5-1:0]  req_funct;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [IDW-1:0]  rsp_id;
    logic [31:0]     rsp_result;
    logic            rsp_err_obs;
`ifdef ALU_ARB_ONEHOT_CHECK_EN
    logic            rsp_err;
    assign rsp_err_obs = rsp_err;
`else
    assign rsp_err_obs = 1'b0;
`endif

    int n_vec = 0;
    int n_err = 0;

    logic [W-1:0] exp_q[$];

    alu_arbiter #(.N_REQ(N), .ID_W(IDW)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_val1   (req_val1),
        .req_val2   (req_val2),
        .req_funct  (req_funct),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
`ifdef ALU_ARB_ONEHOT_CHECK_EN
        .rsp_err    (rsp_err),
`endif
        .rsp_result (rsp_result)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        n_err++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1, "watchdog");
    end

    // ---------------- compare helper ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int popc5(input logic [4:0] f);
        int c = 0;
        for (int k = 0; k < 5; k++) if (f[k]) c++;
        return c;
    endfunction

    function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                            input logic [4:0] f);
        logic [31:0] r;
        r = 32'd0;
`ifdef ALU_ARB_ONEHOT_CHECK_EN
        if (popc5(f) != 1) return 32'd0;
`endif
        if (f[0]) r = r | (a + b);
        if (f[1]) r = r | (a - b);
        if (f[2]) r = r | (a << b);
        if (f[3]) r = r | (a >> b);
        if (f[4]) r = r | $unsigned($signed(a) >>> b);
        return r;
    endfunction

    function automatic logic ref_err(input logic [4:0] f);
`ifdef ALU_ARB_ONEHOT_CHECK_EN
        return popc5(f) != 1;
`else
        return 1'b0;
`endif
    endfunction

    bit          m_full, n_full;
    int          m_id, n_id, m_ptr, n_ptr;
    logic [31:0] m_res, n_res;
    bit          m_err, n_err_bit;

    initial begin
        m_full = 0; m_id = 0; m_ptr = 0; m_res = 0; m_err = 0;
        n_full = 0; n_id = 0; n_ptr = 0; n_res = 0; n_err_bit = 0;
    end

    // One compare process: outputs are checked every cycle mid-period.
    always @(negedge clk) begin
        bit          can;
        int          g;
        logic [N-1:0] exp_ready;
        logic [W-1:0] item;
        if (reset) begin
            m_full = 0; m_id = 0; m_ptr = 0; m_res = 0; m_err = 0;
            exp_q.delete();
        end
        can = !reset && (!m_full || rsp_ready);
        g = -1;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (m_ptr + k) % N;
            if (g < 0 && req_valid[idx]) g = idx;
        end
        exp_ready = '0;
        if (can && g >= 0) exp_ready[g] = 1'b1;

        check("m_rsp_valid", 64'(rsp_valid), 64'(m_full));
        check("m_rsp_id", 64'(rsp_id), 64'(m_id));
        check("m_rsp_result", 64'(rsp_result), 64'(m_res));
        check("m_rsp_err", 64'(rsp_err_obs), 64'(m_err));
        check("m_req_ready", 64'(req_ready), 64'(exp_ready));

        // Transaction scoreboard: each consumed response matches the oldest expected.
        if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_rsp", 64'(1), 64'(0));
            end else begin
                item = exp_q.pop_front();
                check("sb_rsp", 64'({rsp_err_obs, rsp_id, rsp_result}), 64'(item));
            end
        end

        n_full = m_full; n_id = m_id; n_ptr = m_ptr; n_res = m_res; n_err_bit = m_err;
        if (can && g >= 0) begin
            n_full    = 1;
            n_id      = g;
            n_res     = ref_alu(req_val1[g*32 +: 32], req_val2[g*32 +: 32], req_funct[g*5 +: 5]);
            n_err_bit = ref_err(req_funct[g*5 +: 5]);
            n_ptr     = (g + 1) % N;
            exp_q.push_back({n_err_bit, IDW'(g), n_res});
        end else if (m_full && rsp_ready) begin
            n_full = 0;
        end
    end

    always @(posedge clk) begin
        m_full = n_full; m_id = n_id; m_ptr = n_ptr; m_res = n_res; m_err = n_err_bit;
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        req_valid = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic set_op(input int r, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] f);
        req_val1[r*32 +: 32] = a;
        req_val2[r*32 +: 32] = b;
        req_funct[r*5 +: 5]  = f;
    endtask

    task automatic single_op(input string name, input int r, input logic [31:0] a,
                             input logic [31:0] b, input logic [4:0] f,
                             input logic [31:0] exp_res, input logic exp_e);
        bit got;
        @(posedge clk); #1;
        req_valid = '0;
        req_valid[r] = 1'b1;
        set_op(r, a, b, f);
        rsp_ready = 1'b1;
        got = 0;
        for (int t = 0; t < 20 && !got; t++) begin
            @(negedge clk);
            if (req_ready[r]) got = 1;
        end
        check({name, "_accept"}, 64'(got), 64'(1));
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        check({name, "_valid"}, 64'(rsp_valid), 64'(1));
        check({name, "_id"}, 64'(rsp_id), 64'(r));
        check({name, "_result"}, 64'(rsp_result), 64'(exp_res));
        check({name, "_err"}, 64'(rsp_err_obs), 64'(exp_e));
    endtask

    task automatic rand_op(input int r);
        logic [31:0] a, b;
        logic [4:0]  f;
        case ($urandom_range(0, 9))
            0:       f = 5'd0;
            1:       f = 5'($urandom_range(0, 31));
            default: f = 5'(1 << $urandom_range(0, 4));
        endcase
        a = ($urandom_range(0, 4) == 0) ? 32'h8000_0000 : $urandom;
        b = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 40));
        set_op(r, a, b, f);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [N-1:0] acc;
        reset = 1'b1;
        req_valid = '0;
        req_val1 = '0;
        req_val2 = '0;
        req_funct = '0;
        rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset values with all requesters idle.
        @(negedge clk);
        check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("rst_req_ready", 64'(req_ready), 64'(0));
        check("rst_rsp_result", 64'(rsp_result), 64'(0));
        check("rst_rsp_id", 64'(rsp_id), 64'(0));

        // Arithmetic and shifts, literal expectations.
        single_op("add_wrap", 0, 32'hFFFF_FFFF, 32'd1, 5'b00001, 32'h0000_0000, 1'b0);
        single_op("sub_neg", 1, 32'd5, 32'd7, 5'b00010, 32'hFFFF_FFFE, 1'b0);
        single_op("sll_31", 2, 32'd1, 32'd31, 5'b00100, 32'h8000_0000, 1'b0);
        single_op("srl_40", 3, 32'h8000_0000, 32'd40, 5'b01000, 32'h0000_0000, 1'b0);
        single_op("sra_4", 0, 32'h8000_0000, 32'd4, 5'b10000, 32'hF800_0000, 1'b0);
        single_op("sra_33", 1, 32'h8000_0000, 32'd33, 5'b10000, 32'hFFFF_FFFF, 1'b0);
`ifdef ALU_ARB_ONEHOT_CHECK_EN
        single_op("funct_00011", 2, 32'd3, 32'd1, 5'b00011, 32'h0000_0000, 1'b1);
        single_op("funct_zero", 3, 32'd3, 32'd1, 5'b00000, 32'h0000_0000, 1'b1);
`else
        single_op("funct_00011", 2, 32'd3, 32'd1, 5'b00011, 32'h0000_0006, 1'b0);
        single_op("funct_zero", 3, 32'd3, 32'd1, 5'b00000, 32'h0000_0000, 1'b0);
`endif

        // Strict rotation with every requester valid.
        do_reset();
        @(posedge clk); #1;
        for (int i = 0; i < N; i++) set_op(i, 32'(i * 16), 32'd1, 5'b00001);
        req_valid = '1;
        rsp_ready = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("rot_valid", 64'(rsp_valid), 64'(1));
            check("rot_id", 64'(rsp_id), 64'(k % N));
        end
        @(posedge clk); #1;
        req_valid = '0;

        // Backpressure, then drain plus refill with no bubble.
        do_reset();
        @(posedge clk); #1;
        set_op(0, 32'd10, 32'd20, 5'b00001);
        set_op(1, 32'd5, 32'd7, 5'b00010);
        req_valid = 4'b0011;
        rsp_ready = 1'b0;
        @(negedge clk);
        check("bp_first_ready", 64'(req_ready), 64'(4'b0001));
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_ready_low", 64'(req_ready), 64'(0));
            check("bp_valid", 64'(rsp_valid), 64'(1));
            check("bp_id", 64'(rsp_id), 64'(0));
            check("bp_result", 64'(rsp_result), 64'(30));
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", 64'(req_ready), 64'(4'b0010));
        @(negedge clk);
        check("bp_nobubble_valid", 64'(rsp_valid), 64'(1));
        check("bp_nobubble_id", 64'(rsp_id), 64'(1));
        check("bp_nobubble_result", 64'(rsp_result), 64'(32'hFFFF_FFFE));
        @(posedge clk); #1;
        req_valid = '0;

        // Reset while FULL drops the response immediately and for good.
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        req_valid = 4'b0100;
        set_op(2, 32'd9, 32'd9, 5'b00001);
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        check("midrst_full", 64'(rsp_valid), 64'(1));
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        check("midrst_async_clear", 64'(rsp_valid), 64'(0));
        @(posedge clk); #1;
        reset = 1'b0;
        rsp_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("midrst_no_late_rsp", 64'(rsp_valid), 64'(0));
        end

        // Randomized traffic against the model.
        acc = '0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            acc = req_ready;
            @(posedge clk); #1;
            if (reset) begin
                reset = 1'b0;
            end else if ($urandom_range(0, 199) == 0) begin
                reset = 1'b1;
            end
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] || acc[i]) begin
                    req_valid[i] = ($urandom_range(0, 3) != 0);
                    rsp_ready = rsp_ready;
                    rand_op(i);
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        req_valid = '0;
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
